// File: rtl/accumulator_pkg.sv
// Shared control-unit types for the
// program-offset accumulator.
package BusTypes;

  typedef enum logic [1:0] {
    ACC_HOLD = 2'b00,
    ACC_INC  = 2'b01,
    ACC_ADD  = 2'b10,
    ACC_LOAD = 2'b11
  } acc_ctrl_t;

  localparam int ACC_WIDTH = 32;
  localparam int ACC_STEP  = 1;

endpackage

// File: rtl/accumulator.sv
// Fetch-offset accumulator: hold, step,
// add or load, with a one-cycle wrap flag.
module accumulator
  import BusTypes::*;
#(
  parameter int WIDTH = ACC_WIDTH,
  parameter int STEP  = ACC_STEP
) (
  input  logic             clk,
  input  logic             init_n,
  input  logic [WIDTH-1:0] in_val,
  input  acc_ctrl_t        ctrl,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] prev,
  output logic             wrapped
);

  localparam logic [WIDTH-1:0] STEP_V =
    WIDTH'(STEP);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH:0]   sum;

  // in_val only reaches the adder in ADD,
  // so an unknown operand cannot leak into
  // HOLD or INC; unknown ctrl falls to HOLD.
  always_comb begin
    opnd   = STEP_V;
    sum    = '0;
    acc_d  = acc_q;
    prev_d = prev_q;
    wrap_d = 1'b0;
    case (ctrl)
      ACC_INC: begin
        opnd   = STEP_V;
        sum    = {1'b0, acc_q} + {1'b0, opnd};
        acc_d  = sum[WIDTH-1:0];
        prev_d = acc_q;
        wrap_d = sum[WIDTH];
      end
      ACC_ADD: begin
        opnd   = in_val;
        sum    = {1'b0, acc_q} + {1'b0, opnd};
        acc_d  = sum[WIDTH-1:0];
        prev_d = acc_q;
        wrap_d = sum[WIDTH];
      end
      ACC_LOAD: begin
        acc_d  = in_val;
        prev_d = acc_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!init_n) begin
      acc_q  <= '0;
      prev_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      prev_q <= prev_d;
      wrap_q <= wrap_d;
    end
  end

  assign acc     = acc_q;
  assign prev    = prev_q;
  assign wrapped = wrap_q;

endmodule

// File: tb/tb_accumulator.sv
// Vector-table and scoreboard bench for
// the fetch-offset accumulator.
module tb_accumulator;
  import BusTypes::*;

  localparam int W = 32;

  typedef struct {
    logic            rst_n;
    acc_ctrl_t       op;
    logic [W-1:0]    val;
    logic [W-1:0]    e_acc;
    logic [W-1:0]    e_prev;
    logic            e_wrap;
  } vec_t;

  typedef struct {
    logic [W-1:0] e_acc;
    logic [W-1:0] e_prev;
    logic         e_wrap;
  } exp_t;

  logic         clk = 1'b0;
  logic         init_n;
  logic [W-1:0] in_val;
  acc_ctrl_t    ctrl;
  logic [W-1:0] acc;
  logic [W-1:0] prev;
  logic         wrapped;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];
  vec_t tbl[18];

  accumulator #(.WIDTH(W), .STEP(1)) dut (
    .clk     (clk),
    .init_n  (init_n),
    .in_val  (in_val),
    .ctrl    (ctrl),
    .acc     (acc),
    .prev    (prev),
    .wrapped (wrapped)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm,
                     input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h",
               nm, got, exp);
    end
  endtask

  task automatic step(input string nm,
                      input logic r,
                      input acc_ctrl_t op,
                      input logic [W-1:0] v,
                      input logic [W-1:0] ea,
                      input logic [W-1:0] ep,
                      input logic ew);
    exp_t e;
    @(negedge clk);
    init_n = r;
    ctrl   = op;
    in_val = v;
    e.e_acc  = ea;
    e.e_prev = ep;
    e.e_wrap = ew;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard empty", nm);
    end else begin
      e = sb.pop_front();
      chk({nm, ".acc"}, acc, e.e_acc);
      chk({nm, ".prev"}, prev, e.e_prev);
      chk({nm, ".wrap"}, {{(W-1){1'b0}}, wrapped},
          {{(W-1){1'b0}}, e.e_wrap});
    end
  endtask

  initial begin
    init_n = 1'b0;
    ctrl   = ACC_INC;
    in_val = '0;

    tbl[0]  = '{1'b0, ACC_INC,  '0, 0, 0, 1'b0};
    tbl[1]  = '{1'b0, ACC_INC,  '0, 0, 0, 1'b0};
    tbl[2]  = '{1'b1, ACC_INC,  '0, 1, 0, 1'b0};
    tbl[3]  = '{1'b1, ACC_INC,  '0, 2, 1, 1'b0};
    tbl[4]  = '{1'b1, ACC_INC,  '0, 3, 2, 1'b0};
    tbl[5]  = '{1'b1, ACC_INC,  '0, 4, 3, 1'b0};
    tbl[6]  = '{1'b1, ACC_INC,  '0, 5, 4, 1'b0};
    tbl[7]  = '{1'b1, ACC_LOAD, 32'h100,
                256, 5, 1'b0};
    tbl[8]  = '{1'b1, ACC_HOLD, 'x, 256, 5, 1'b0};
    tbl[9]  = '{1'b1, ACC_HOLD, 'x, 256, 5, 1'b0};
    tbl[10] = '{1'b1, ACC_HOLD, 'x, 256, 5, 1'b0};
    tbl[11] = '{1'b1, ACC_LOAD, 32'hFFFF_FFFF,
                32'hFFFF_FFFF, 256, 1'b0};
    tbl[12] = '{1'b1, ACC_INC,  'x,
                0, 32'hFFFF_FFFF, 1'b1};
    tbl[13] = '{1'b1, ACC_HOLD, '0,
                0, 32'hFFFF_FFFF, 1'b0};
    tbl[14] = '{1'b1, ACC_LOAD, 5, 5, 0, 1'b0};
    tbl[15] = '{1'b1, ACC_ADD,  10, 15, 5, 1'b0};
    tbl[16] = '{1'b1, ACC_ADD,  32'hFFFF_FFFF,
                14, 15, 1'b1};
    tbl[17] = '{1'b1, ACC_LOAD, 7, 7, 14, 1'b0};

    for (int i = 0; i < 18; i++)
      step($sformatf("vec%0d", i),
           tbl[i].rst_n, tbl[i].op, tbl[i].val,
           tbl[i].e_acc, tbl[i].e_prev,
           tbl[i].e_wrap);

    // reset lands mid-INC, then INC resumes
    step("rst_mid", 1'b0, ACC_INC, '0, 0, 0, 1'b0);
    step("rst_rel", 1'b1, ACC_INC, '0, 1, 0, 1'b0);
    step("ctrl_x", 1'b1, acc_ctrl_t'(2'bxx),
         32'h55, 1, 0, 1'b0);

    // edge of wrap, then ADD carry, then clear
    step("ld_fe", 1'b1, ACC_LOAD, 32'hFFFF_FFFE,
         32'hFFFF_FFFE, 1, 1'b0);
    step("inc_nw", 1'b1, ACC_INC, '0,
         32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    step("add_c", 1'b1, ACC_ADD, 2,
         1, 32'hFFFF_FFFF, 1'b1);
    step("ld_clr", 1'b1, ACC_LOAD, 3, 3, 1, 1'b0);
    step("add_w2", 1'b1, ACC_ADD, 32'hFFFF_FFFD,
         0, 3, 1'b1);
    step("rst_w", 1'b0, ACC_ADD, 5, 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
